// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for clk_period_meter.
//   meter_state_e : measurement FSM states (IDLE, MEAS)
//   sat_inc       : increment that stops at a limit
//   within_tol    : |meas - expv| <= tol, without wrap
// The helpers work on MAX_W-bit operands. Callers zero-extend narrower
// values and truncate the result back, so W may be at most MAX_W.
package clk_meter_pkg;

   localparam int MAX_W = 32;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } meter_state_e;

   function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                                input logic [MAX_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

   // The difference is taken one bit wider than the operands, so neither
   // operand order can wrap.
   function automatic logic within_tol(input logic [MAX_W-1:0] meas,
                                       input logic [MAX_W-1:0] expv,
                                       input logic [MAX_W-1:0] tol);
      logic [MAX_W:0] diff;
      if (meas >= expv) diff = {1'b0, meas} - {1'b0, expv};
      else              diff = {1'b0, expv} - {1'b0, meas};
      return diff <= {1'b0, tol};
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous input into the clk domain and detects its edges.
// The input passes through a two-flop synchronizer and then one delay flop.
//   clk      : sampling clock
//   srst     : synchronous active-high reset; clears all flops to 0
//   async_in : asynchronous input
//   level    : synchronized level (second synchronizer flop)
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// rise and fall can never be high together.
module sync_edge_det (
   input  logic clk,
   input  logic srst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = async_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~s3_q;
   assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow, clock-like signal in CLK_IN cycles.
// The optional high-time measurement is controlled by the macro
// CLK_PERIOD_METER_DUTY_EN.
//   CLK_IN    : system clock; everything runs on its rising edge
//   RST       : synchronous active-high reset
//   SIG_IN    : measured signal, asynchronous to CLK_IN
//   PERIOD    : last measured period (cycles between synchronized rises)
//   HIGH_TIME : last measured high time (present only with the macro)
//   VALID     : one-cycle strobe when PERIOD/HIGH_TIME update
//   LOCK      : LOCK_CNT consecutive periods within EXP_PERIOD +/- TOL
//   TMO       : sticky; set after TIMEOUT cycles without a rise, and
//               cleared by the next rise
// The first rise after reset or after a timeout only arms the
// measurement. No VALID is issued for it.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int W          = 16,
   parameter int EXP_PERIOD = 20,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 4,
   parameter int TIMEOUT    = 1000
) (
   input  logic         CLK_IN,
   input  logic         RST,
   input  logic         SIG_IN,
   output logic [W-1:0] PERIOD,
`ifdef CLK_PERIOD_METER_DUTY_EN
   output logic [W-1:0] HIGH_TIME,
`endif
   output logic         VALID,
   output logic         LOCK,
   output logic         TMO
);

   localparam int              MW        = $clog2(LOCK_CNT + 1);
   localparam logic [W-1:0]    CNT_MAX   = '1;
   localparam logic [W-1:0]    TMO_LAST  = W'(TIMEOUT - 1);
   localparam logic [MW-1:0]   MATCH_MAX = MW'(LOCK_CNT);

   logic sig_level_unused;
   logic rise, fall;

   sync_edge_det u_sync (
      .clk      (CLK_IN),
      .srst     (RST),
      .async_in (SIG_IN),
      .level    (sig_level_unused),
      .rise     (rise),
      .fall     (fall)
   );

   meter_state_e  state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]  period_q, period_d;
   logic          valid_q, valid_d;
   logic          lock_q, lock_d;
   logic          tmo_q, tmo_d;
   logic [MW-1:0] match_q, match_d;
   logic [W-1:0]  cnt_inc;
   logic          timeout_hit;
`ifdef CLK_PERIOD_METER_DUTY_EN
   logic [W-1:0]  high_cap_q, high_cap_d;
   logic [W-1:0]  high_time_q, high_time_d;
`else
   logic          fall_unused;
   assign fall_unused = fall;
`endif

   always_comb begin
      cnt_inc     = W'(sat_inc(MAX_W'(cnt_q), MAX_W'(CNT_MAX)));
      state_d     = state_q;
      cnt_d       = rise ? '0 : cnt_inc;
      period_d    = period_q;
      valid_d     = 1'b0;
      lock_d      = lock_q;
      tmo_d       = tmo_q;
      match_d     = match_q;
      timeout_hit = 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_EN
      high_cap_d  = high_cap_q;
      high_time_d = high_time_q;
`endif

      // Any rise clears the timeout, including the arming rise in IDLE.
      if (rise) tmo_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (rise) state_d = MEAS;
         end
         MEAS: begin
            if (rise) begin
               // The count restarts at 0 on a rise, so the spacing is cnt+1.
               period_d = cnt_inc;
               valid_d  = 1'b1;
`ifdef CLK_PERIOD_METER_DUTY_EN
               high_time_d = high_cap_q;
`endif
            end else if (cnt_q == TMO_LAST) begin
               timeout_hit = 1'b1;
               tmo_d       = 1'b1;
               state_d     = IDLE;
            end
`ifdef CLK_PERIOD_METER_DUTY_EN
            if (fall) high_cap_d = cnt_inc;
`endif
         end
         default: state_d = IDLE;
      endcase

      // The lock check runs one cycle after the measurement, on the
      // registered PERIOD. That makes LOCK follow VALID by one cycle.
      if (valid_q) begin
         if (within_tol(MAX_W'(period_q), MAX_W'(EXP_PERIOD), MAX_W'(TOL))) begin
            match_d = MW'(sat_inc(MAX_W'(match_q), MAX_W'(MATCH_MAX)));
            if (match_d == MATCH_MAX) lock_d = 1'b1;
         end else begin
            match_d = '0;
            lock_d  = 1'b0;
         end
      end

      if (timeout_hit) begin
         match_d = '0;
         lock_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         valid_q     <= 1'b0;
         lock_q      <= 1'b0;
         tmo_q       <= 1'b0;
         match_q     <= '0;
`ifdef CLK_PERIOD_METER_DUTY_EN
         high_cap_q  <= '0;
         high_time_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         valid_q     <= valid_d;
         lock_q      <= lock_d;
         tmo_q       <= tmo_d;
         match_q     <= match_d;
`ifdef CLK_PERIOD_METER_DUTY_EN
         high_cap_q  <= high_cap_d;
         high_time_q <= high_time_d;
`endif
      end
   end

   assign PERIOD = period_q;
   assign VALID  = valid_q;
   assign LOCK   = lock_q;
   assign TMO    = tmo_q;
`ifdef CLK_PERIOD_METER_DUTY_EN
   assign HIGH_TIME = high_time_q;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed testbench for clk_period_meter. Instance A uses the default
// parameters. Instance B uses a 4-bit counter with TIMEOUT=15 to cover
// the case of edges that arrive just before saturation.
// HIGH_TIME is checked when CLK_PERIOD_METER_DUTY_EN is defined.
module tb_clk_period_meter;
   import clk_meter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic sig_a, sig_b;
   logic [15:0] period_a;
   logic [15:0] high_a = '0;
   logic        valid_a, lock_a, tmo_a;
   logic [3:0]  period_b;
   logic [3:0]  high_b = '0;
   logic        valid_b, lock_b, tmo_b;
   logic        tmo_b_seen = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   clk_period_meter dut_a (
      .CLK_IN    (clk),
      .RST       (rst),
      .SIG_IN    (sig_a),
      .PERIOD    (period_a),
`ifdef CLK_PERIOD_METER_DUTY_EN
      .HIGH_TIME (high_a),
`endif
      .VALID     (valid_a),
      .LOCK      (lock_a),
      .TMO       (tmo_a)
   );

   clk_period_meter #(
      .W(4), .EXP_PERIOD(14), .TOL(1), .LOCK_CNT(4), .TIMEOUT(15)
   ) dut_b (
      .CLK_IN    (clk),
      .RST       (rst),
      .SIG_IN    (sig_b),
      .PERIOD    (period_b),
`ifdef CLK_PERIOD_METER_DUTY_EN
      .HIGH_TIME (high_b),
`endif
      .VALID     (valid_b),
      .LOCK      (lock_b),
      .TMO       (tmo_b)
   );

   always @(negedge clk) if (tmo_b) tmo_b_seen = 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
      end
   endtask

   task automatic set_sig(input bit which, input logic v);
      if (!which) sig_a = v;
      else        sig_b = v;
   endtask

   task automatic sample(input bit which, output logic v, output logic t,
                         output logic l, output logic [15:0] p, output logic [15:0] h);
      if (!which) begin
         v = valid_a; t = tmo_a; l = lock_a; p = period_a; h = high_a;
      end else begin
         v = valid_b; t = tmo_b; l = lock_b; p = {12'd0, period_b}; h = {12'd0, high_b};
      end
   endtask

   // One pulse: hi cycles high, then lo cycles low. The rise is visible as
   // VALID three cycles after SIG goes high. LOCK is checked in the VALID
   // cycle (lock_pre) and in the cycle after it (lock_post).
   task automatic edge_cycle(input bit which, input int hi, input int lo,
                             input bit exp_valid, input int exp_p, input int exp_h,
                             input bit lock_pre, input bit lock_post);
      logic v, t, l;
      logic [15:0] p, h;
      set_sig(which, 1'b1);
      repeat (3) tick();
      sample(which, v, t, l, p, h);
      chk("valid_at_rise", 32'(v), 32'(exp_valid));
      chk("tmo_after_rise", 32'(t), 32'd0);
      chk("lock_in_valid_cycle", 32'(l), 32'(lock_pre));
      if (exp_valid) begin
         chk("period", 32'(p), 32'(exp_p));
`ifdef CLK_PERIOD_METER_DUTY_EN
         chk("high_time", 32'(h), 32'(exp_h));
`endif
      end
      tick();
      sample(which, v, t, l, p, h);
      chk("valid_one_cycle", 32'(v), 32'd0);
      chk("lock_after_valid", 32'(l), 32'(lock_post));
      repeat (hi - 4) tick();
      set_sig(which, 1'b0);
      repeat (lo) tick();
   endtask

   initial begin
      rst = 1'b1; sig_a = 1'b0; sig_b = 1'b0;
      repeat (5) tick();
      chk("rst_period", 32'(period_a), 32'd0);
      chk("rst_valid",  32'(valid_a),  32'd0);
      chk("rst_lock",   32'(lock_a),   32'd0);
      chk("rst_tmo",    32'(tmo_a),    32'd0);
      chk("rst_high",   32'(high_a),   32'd0);
      chk("rst_state",  32'(dut_a.state_q), 32'(IDLE));
      chk("rst_b_period", 32'(period_b), 32'd0);
      rst = 1'b0;
      repeat (3) tick();

      // Arming rise, then a period-20 square wave. Lock follows the 4th VALID.
      edge_cycle(0, 10, 10, 0, 0, 0, 0, 0);
      chk("armed_state", 32'(dut_a.state_q), 32'(MEAS));
      edge_cycle(0, 10, 10, 1, 20, 10, 0, 0);
      edge_cycle(0, 10, 10, 1, 20, 10, 0, 0);
      edge_cycle(0, 10, 10, 1, 20, 10, 0, 0);
      edge_cycle(0, 10, 10, 1, 20, 10, 0, 1);
      // One period of 23 breaks lock. Four periods of 21 restore it.
      edge_cycle(0, 12, 11, 1, 20, 10, 1, 1);
      edge_cycle(0, 10, 11, 1, 23, 12, 1, 0);
      edge_cycle(0, 10, 11, 1, 21, 10, 0, 0);
      edge_cycle(0, 10, 11, 1, 21, 10, 0, 0);
      edge_cycle(0, 10, 11, 1, 21, 10, 0, 0);
      edge_cycle(0, 10, 11, 1, 21, 10, 0, 1);

      // Timeout: the last rise, then no more edges.
      sig_a = 1'b1;
      repeat (3) tick();
      chk("to_last_valid",  32'(valid_a),  32'd1);
      chk("to_last_period", 32'(period_a), 32'd21);
      repeat (999) tick();
      chk("to_tmo_999", 32'(tmo_a),  32'd0);
      chk("to_lock_999", 32'(lock_a), 32'd1);
      tick();
      chk("to_tmo_1000",  32'(tmo_a),  32'd1);
      chk("to_lock_1000", 32'(lock_a), 32'd0);
      chk("to_state", 32'(dut_a.state_q), 32'(IDLE));
      sig_a = 1'b0;
      repeat (5) tick();
      chk("to_sticky", 32'(tmo_a), 32'd1);
      edge_cycle(0, 10, 10, 0, 0, 0, 0, 0);
      edge_cycle(0, 10, 10, 1, 20, 10, 0, 0);

      // Reset 7 cycles into a period.
      sig_a = 1'b1;
      repeat (3) tick();
      chk("mr_valid",  32'(valid_a),  32'd1);
      chk("mr_period", 32'(period_a), 32'd20);
      repeat (7) tick();
      rst = 1'b1; sig_a = 1'b0;
      repeat (3) tick();
      chk("mr_rst_period", 32'(period_a), 32'd0);
      chk("mr_rst_valid",  32'(valid_a),  32'd0);
      chk("mr_rst_lock",   32'(lock_a),   32'd0);
      chk("mr_rst_tmo",    32'(tmo_a),    32'd0);
      chk("mr_rst_high",   32'(high_a),   32'd0);
      chk("mr_rst_state",  32'(dut_a.state_q), 32'(IDLE));
      rst = 1'b0;
      repeat (5) tick();
      edge_cycle(0, 10, 10, 0, 0, 0, 0, 0);
      chk("mr_armed_state", 32'(dut_a.state_q), 32'(MEAS));
      edge_cycle(0, 10, 10, 1, 20, 10, 0, 0);

      // Narrow counter: rises 14 apart must never reach the timeout.
      edge_cycle(1, 7, 7, 0, 0, 0, 0, 0);
      edge_cycle(1, 7, 7, 1, 14, 7, 0, 0);
      edge_cycle(1, 7, 7, 1, 14, 7, 0, 0);
      edge_cycle(1, 7, 7, 1, 14, 7, 0, 0);
      edge_cycle(1, 7, 7, 1, 14, 7, 0, 1);
      edge_cycle(1, 7, 7, 1, 14, 7, 1, 1);
      chk("sat_no_tmo", 32'(tmo_b_seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
